// File: rtl/replacement_ctrl.sv
// Sequencing controller for the cache replacement policy: forwards hit updates,
// holds the victim way across a refill, owns policy invalidation and hit/miss statistics.
module replacement_ctrl #(
  parameter int N_WAYS        = 8,
  parameter int LINE_OFFSET_W = 7,
  parameter int NWAY_W        = $clog2(N_WAYS),
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [LINE_OFFSET_W-1:0] req_index,
  input  logic [N_WAYS-1:0]        req_hit,
  output logic                     victim_valid,
  output logic [N_WAYS-1:0]        victim_way,
  output logic [NWAY_W-1:0]        victim_bin,
  input  logic                     fill_done,
  input  logic                     invalidate,
  output logic                     rep_write_en,
  output logic [N_WAYS-1:0]        rep_way_hit,
  output logic [LINE_OFFSET_W-1:0] rep_line_addr,
  output logic                     rep_reset,
  input  logic [N_WAYS-1:0]        rep_way_select,
  input  logic [NWAY_W-1:0]        rep_way_select_bin,
  input  logic                     cnt_clear,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  typedef enum logic [1:0] {IDLE, HIT_UPD, MISS_WAIT, FILL_UPD} state_t;

  state_t                   state;
  logic [LINE_OFFSET_W-1:0] idx_q;
  logic                     accept;
  logic                     is_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign req_ready     = (state == IDLE) & ~invalidate & ~reset;
  assign accept        = req_valid & req_ready;
  assign is_hit        = |req_hit;
  assign rep_reset     = reset | invalidate;
  // The policy lookup is combinational, so the victim is already valid in the accept cycle.
  assign rep_line_addr = (state == IDLE) ? req_index : idx_q;

  always_ff @(posedge clk) begin
    if (accept) idx_q <= req_index;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rep_write_en <= 1'b0;
      rep_way_hit  <= '0;
      victim_valid <= 1'b0;
      victim_way   <= '0;
      victim_bin   <= '0;
    end else begin
      rep_write_en <= 1'b0;
      rep_way_hit  <= '0;
      if (invalidate) begin
        state        <= IDLE;
        victim_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (is_hit) begin
                state        <= HIT_UPD;
                rep_write_en <= 1'b1;
                rep_way_hit  <= req_hit;
              end else begin
                state        <= MISS_WAIT;
                victim_way   <= rep_way_select;
                victim_bin   <= rep_way_select_bin;
                victim_valid <= 1'b1;
              end
            end
          end
          HIT_UPD:  state <= IDLE;
          MISS_WAIT: begin
            if (fill_done) begin
              state        <= FILL_UPD;
              victim_valid <= 1'b0;
              rep_write_en <= 1'b1;
              rep_way_hit  <= victim_way;
            end
          end
          FILL_UPD: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // Statistics survive invalidate; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (is_hit) hit_cnt  <= sat_inc(hit_cnt);
      else        miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_replacement_ctrl.sv
// Bench for replacement_ctrl: a tree-PLRU policy stands in for the real policy block,
// and a transaction-level model predicts every output each cycle.
module tb_replacement_ctrl;
  localparam int NW   = 8;
  localparam int LW   = 7;
  localparam int BW   = 3;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic          clk, reset, req_valid, req_ready, victim_valid, fill_done, invalidate;
  logic [LW-1:0] req_index, rep_line_addr;
  logic [NW-1:0] req_hit, victim_way, rep_way_hit, rep_way_select;
  logic [BW-1:0] victim_bin, rep_way_select_bin;
  logic          rep_write_en, rep_reset, cnt_clear;
  logic [CW-1:0] hit_cnt, miss_cnt;

  replacement_ctrl #(.N_WAYS(NW), .LINE_OFFSET_W(LW), .NWAY_W(BW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_hit(req_hit), .victim_valid(victim_valid),
    .victim_way(victim_way), .victim_bin(victim_bin), .fill_done(fill_done),
    .invalidate(invalidate), .rep_write_en(rep_write_en), .rep_way_hit(rep_way_hit),
    .rep_line_addr(rep_line_addr), .rep_reset(rep_reset), .rep_way_select(rep_way_select),
    .rep_way_select_bin(rep_way_select_bin), .cnt_clear(cnt_clear),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Tree PLRU per line: heap nodes 1..7, each bit points toward the less recently used half.
  logic [7:0] plru [128];

  function automatic int victim_of(input logic [7:0] t);
    int n = 1;
    for (int l = 0; l < 3; l++) n = 2 * n + int'(t[n]);
    return n - 8;
  endfunction

  function automatic logic [7:0] touched(input logic [7:0] t, input int w);
    int n = w + 8;
    while (n > 1) begin
      t[n / 2] = (n % 2 == 0);
      n = n / 2;
    end
    return t;
  endfunction

  function automatic int oh2bin(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always_comb begin
    rep_way_select_bin = 3'(victim_of(plru[rep_line_addr]));
    rep_way_select     = 8'(1) << rep_way_select_bin;
  end

  always @(posedge clk) begin
    if (rep_reset) begin
      for (int i = 0; i < 128; i++) plru[i] <= '0;
    end else if (rep_write_en) begin
      plru[rep_line_addr] <= touched(plru[rep_line_addr], oh2bin(rep_way_hit));
    end
  end

  // Expected outputs for the current cycle.
  bit         m_idle, m_wait, m_vv, m_we;
  logic [7:0] m_wh, m_vway;
  int         m_vbin, m_addr, m_hits, m_misses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 0; req_index = '0; req_hit = '0;
    fill_done = 0; invalidate = 0; cnt_clear = 0;
    @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rep_reset", rep_reset, 1);
    check("rst_vvalid", victim_valid, 0);
    check("rst_we", rep_write_en, 0);
    check("rst_way_hit", rep_way_hit, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_victim_way", victim_way, 0);
    check("rst_victim_bin", victim_bin, 0);
    @(negedge clk);
    reset = 1'b0;
    m_idle = 1; m_wait = 0; m_vv = 0; m_we = 0; m_wh = '0;
    m_vway = '0; m_vbin = 0; m_addr = 0; m_hits = 0; m_misses = 0;
  endtask

  // One clock cycle: apply inputs, compare every output, advance the model.
  task automatic step(input bit v, input int idx, input logic [7:0] hit,
                      input bit fd, input bit inv, input bit clr);
    bit acc;
    int vb;
    req_valid = v; req_index = 7'(idx); req_hit = hit;
    fill_done = fd; invalidate = inv; cnt_clear = clr;
    #1;
    check("req_ready", req_ready, m_idle && !inv);
    check("rep_reset", rep_reset, inv);
    check("rep_line_addr", rep_line_addr, m_idle ? idx : m_addr);
    check("rep_write_en", rep_write_en, m_we);
    check("rep_way_hit", rep_way_hit, m_wh);
    check("victim_valid", victim_valid, m_vv);
    check("victim_way", victim_way, m_vway);
    check("victim_bin", victim_bin, m_vbin);
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);

    acc = v && m_idle && !inv;
    if (clr) begin
      m_hits = 0; m_misses = 0;
    end else if (acc) begin
      if (hit != 0) m_hits   = (m_hits + 1 > MAXC) ? MAXC : m_hits + 1;
      else          m_misses = (m_misses + 1 > MAXC) ? MAXC : m_misses + 1;
    end
    m_we = 0; m_wh = '0;
    if (inv) begin
      m_idle = 1; m_wait = 0; m_vv = 0;
    end else if (acc) begin
      m_addr = idx; m_idle = 0;
      if (hit != 0) begin
        m_we = 1; m_wh = hit;
      end else begin
        vb = victim_of(plru[idx]);
        m_vbin = vb; m_vway = 8'(1) << vb; m_vv = 1; m_wait = 1;
      end
    end else if (m_wait) begin
      if (fd) begin
        m_we = 1; m_wh = m_vway; m_vv = 0; m_wait = 0;
      end
    end else if (!m_idle) begin
      m_idle = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Reset then hit on index 5
    step(1, 5, 8'h04, 0, 0, 0);
    check("hit_we", rep_write_en, 1);
    check("hit_way", rep_way_hit, 8'h04);
    check("hit_addr", rep_line_addr, 5);
    step(0, 0, 8'h00, 0, 0, 0);
    check("hit_ready_t2", req_ready, 1);
    check("hit_cnt_1", hit_cnt, 1);

    // Miss and fill on a fresh line
    step(0, 0, 8'h00, 0, 1, 0);
    step(1, 3, 8'h00, 0, 0, 0);
    check("miss_vway", victim_way, 8'h01);
    check("miss_vbin", victim_bin, 0);
    check("miss_vvalid", victim_valid, 1);
    repeat (10) begin
      step(0, 0, 8'h00, 0, 0, 0);
      check("miss_hold_vv", victim_valid, 1);
      check("miss_hold_way", victim_way, 8'h01);
    end
    step(0, 0, 8'h00, 1, 0, 0);
    check("fill_we", rep_write_en, 1);
    check("fill_way", rep_way_hit, 8'h01);
    check("fill_addr", rep_line_addr, 3);
    check("fill_vv_low", victim_valid, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    check("miss_cnt_1", miss_cnt, 1);

    // Eight misses on index 0 walk the whole tree
    step(0, 0, 8'h00, 0, 1, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h00, 0, 0, 0);
      check("seq_bin", victim_bin, seq[k]);
      check("seq_way", victim_way, 8'(1) << seq[k]);
      step(0, 0, 8'h00, 1, 0, 0);
      check("seq_fill_way", rep_way_hit, 8'(1) << seq[k]);
      step(0, 0, 8'h00, 0, 0, 0);
    end
    check("miss_cnt_8", miss_cnt, 8);

    // Invalidate during MISS_WAIT with a competing request
    step(1, 9, 8'h00, 0, 0, 0);
    check("inv_pre_vv", victim_valid, 1);
    step(1, 9, 8'h04, 0, 1, 0);
    check("inv_vv_drop", victim_valid, 0);
    check("inv_no_write", rep_write_en, 0);
    check("inv_no_accept", hit_cnt, 0);
    check("inv_ready_low", req_ready, 0);
    check("inv_rep_reset", rep_reset, 1);
    step(0, 0, 8'h00, 1, 0, 0);
    check("inv_fill_ignored", rep_write_en, 0);
    check("inv_rep_reset_off", rep_reset, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    check("inv_still_idle", rep_write_en, 0);

    // Counter saturation and clear-beats-increment
    step(0, 0, 8'h00, 0, 0, 1);
    repeat (20) begin
      step(1, 2, 8'h10, 0, 0, 0);
      step(0, 0, 8'h00, 0, 0, 0);
    end
    check("hit_sat", hit_cnt, 15);
    step(1, 2, 8'h10, 0, 0, 1);
    check("clr_wins", hit_cnt, 0);
    check("clr_hit_accepted", rep_write_en, 1);
    step(0, 0, 8'h00, 0, 0, 0);

    // Back-to-back hits with req_valid held
    step(1, 1, 8'h02, 0, 0, 0);
    check("b2b_we1", rep_write_en, 1);
    check("b2b_addr1", rep_line_addr, 1);
    step(1, 2, 8'h02, 0, 0, 0);
    check("b2b_gap_we", rep_write_en, 0);
    check("b2b_gap_ready", req_ready, 1);
    step(1, 2, 8'h02, 0, 0, 0);
    check("b2b_addr2", rep_line_addr, 2);
    step(1, 3, 8'h02, 0, 0, 0);
    step(1, 3, 8'h02, 0, 0, 0);
    check("b2b_addr3", rep_line_addr, 3);
    check("b2b_we3", rep_write_en, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    check("b2b_cnt", hit_cnt, 3);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [7:0] h;
      h = ($urandom_range(0, 1) == 1) ? 8'(8'(1) << $urandom_range(0, 7)) : 8'h00;
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 3)), h,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 3);
    end

    do_reset();
    step(0, 0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/replacement_ctrl.md
# replacement_ctrl

Sequencing controller for the cache replacement policy block. It accepts one access report per transaction from the cache control path (line index plus way-hit vector) and drives the policy's `write_en`, `way_hit` and `line_addr`. On a miss it captures and holds the victim way for the refill engine, then commits that way as most recently used once the refill completes. It also owns policy invalidation (a reset pulse to the policy state) and hit/miss statistics counters.

## Interface
- `N_WAYS`, 8: associativity; power of 2, at least 2.
- `LINE_OFFSET_W`, 7: line index width.
- `NWAY_W`, `$clog2(N_WAYS)`: binary way width.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: access report valid.
- `req_ready` out 1: report accepted when `req_valid & req_ready`.
- `req_index` in `LINE_OFFSET_W`: line index of the access.
- `req_hit` in `N_WAYS`: one-hot hit vector; all-zero means miss.
- `victim_valid` out 1: victim way held stable for refill.
- `victim_way` out `N_WAYS`: one-hot victim way.
- `victim_bin` out `NWAY_W`: binary victim way.
- `fill_done` in 1: refill of victim line complete (single-cycle pulse).
- `invalidate` in 1: clear all replacement state.
- `rep_write_en` out 1: to policy `write_en`.
- `rep_way_hit` out `N_WAYS`: to policy `way_hit`.
- `rep_line_addr` out `LINE_OFFSET_W`: to policy `line_addr`.
- `rep_reset` out 1: to policy `reset`.
- `rep_way_select` in `N_WAYS`: from policy `way_select`.
- `rep_way_select_bin` in `NWAY_W`: from policy `way_select_bin`.
- `cnt_clear` in 1: synchronous clear of both counters.
- `hit_cnt` out `CNT_W`: accepted hits, saturating.
- `miss_cnt` out `CNT_W`: accepted misses, saturating.

## Operation
- FSM states are IDLE, HIT_UPD, MISS_WAIT and FILL_UPD. Reset state is IDLE.
- `req_ready = (state==IDLE) & ~invalidate & ~reset`.
- `rep_line_addr` is `req_index` in IDLE and `idx_q` in every other state. The policy read is combinational, so `rep_way_select` is valid in the accept cycle.
- On accept, `idx_q <= req_index`.
- **Hit** (`|req_hit`): `hit_q <= req_hit`, then go to HIT_UPD.
- **Miss**: `victim_q <= rep_way_select`, `victim_bin_q <= rep_way_select_bin`, then go to MISS_WAIT.
- **HIT_UPD**: assert `rep_write_en=1` and `rep_way_hit=hit_q` for one cycle, then go to IDLE.
- **MISS_WAIT**: `victim_valid=1`; `victim_way`/`victim_bin` show the captured values. If `fill_done` is high, go to FILL_UPD. Otherwise stay.
- **FILL_UPD**: assert `rep_write_en=1` and `rep_way_hit=victim_q` for one cycle, then go to IDLE.
- In all other states and cycles: `rep_write_en=0` and `rep_way_hit=0`.
- `fill_done` outside MISS_WAIT is ignored.
- **Invalidate**: `invalidate` high in any state forces IDLE next cycle and asserts `rep_reset` for that cycle.
  - Any pending update is dropped and `victim_valid` falls.
  - Invalidate wins over a simultaneous `req_valid` (request not accepted) and over `fill_done`.
- `rep_reset = reset | invalidate`, combinational.
- **Counters**:
  - `hit_cnt` increments on each accepted hit; `miss_cnt` on each accepted miss.
  - Both saturate at all-ones.
  - `cnt_clear` wins over a same-cycle increment (result 0).
  - Counters are not affected by `invalidate`.
- A multi-hot `req_hit` is counted as a hit and forwarded unchanged; policy behaviour for it is undefined. Callers must not issue it.

## Timing
- During `reset` and on the first cycle after it:
  - `req_ready`=0 while `reset` is high, 1 after.
  - `victim_valid`=0, `rep_write_en`=0, `rep_way_hit`=0.
  - `hit_cnt`=0, `miss_cnt`=0, `victim_way`=0, `victim_bin`=0, `rep_reset`=1 while `reset` is high.
- **Hit**: accept in cycle T, policy write in T+1, `req_ready` high again in T+2. Throughput is one access per 2 cycles.
- **Miss**: accept in T, `victim_valid` from T+1, stable until the cycle after `fill_done`.
  - `fill_done` in cycle F gives a policy write in F+1, `victim_valid` low in F+1, and `req_ready` high in F+2.
- The counter update is visible the cycle after accept.
- `victim_way`/`victim_bin` are registered. They hold their last value outside MISS_WAIT and are zeroed by reset.
- No combinational path from `fill_done` to any output.

## Test plan
- **Reset then hit.** Reset, then a hit on index 5 with `req_hit`=8'b0000_0100.
  - T+1: `rep_write_en`=1, `rep_way_hit`=8'h04, `rep_line_addr`=5.
  - T+2: `req_ready`=1, `hit_cnt`=1.
- **Miss and fill on a fresh line.** Policy reset, tree mode, miss on index 3.
  - `victim_way`=8'h01, `victim_bin`=0, `victim_valid` held for 10 cycles.
  - `fill_done` then gives a write with `rep_way_hit`=8'h01.
  - `miss_cnt`=1.
- **Eight misses on index 0.** Eight misses, each filled.
  - Victim sequence for the tree policy: 0,4,2,6,1,5,3,7.
  - `miss_cnt`=8.
- **Invalidate during MISS_WAIT.** Invalidate with `req_valid` asserted.
  - `rep_reset` pulses 1 cycle, `victim_valid` drops, the request is not accepted, and no policy write follows.
  - A later `fill_done` is ignored.
- **Counter edge cases.** `CNT_W`=4, 20 hits.
  - `hit_cnt` saturates at 15.
  - `cnt_clear` together with a hit accept gives `hit_cnt`=0.
- **Back-to-back hits.** `req_valid` held high with hits on indices 1,2,3.
  - Accepts land every 2 cycles and writes carry the matching index.
